// File: rtl/sumador_pkg.sv
// Shared types for the digit-serial adder/subtractor: operation codes and FSM states.
package sumador_pkg;

    typedef enum logic [1:0] {
        OP_ADD     = 2'b00,
        OP_SUB     = 2'b01,
        OP_ACC_ADD = 2'b10,
        OP_ACC_SUB = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    function automatic logic op_uses_acc(input logic [1:0] op);
        return (op_t'(op) == OP_ACC_ADD) || (op_t'(op) == OP_ACC_SUB);
    endfunction

    function automatic logic op_is_sub(input logic [1:0] op);
        return (op_t'(op) == OP_SUB) || (op_t'(op) == OP_ACC_SUB);
    endfunction

endpackage

// File: rtl/sumador_fragmento.sv
// Combinational CHUNK-bit adder slice; cmsb is the carry into its top bit,
// recovered from the sum bit so no separate narrower adder is needed.
module sumador_fragmento #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [CHUNK:0] full;

    assign full = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
    assign sum  = full[CHUNK-1:0];
    assign cout = full[CHUNK];
    assign cmsb = x[CHUNK-1] ^ y[CHUNK-1] ^ sum[CHUNK-1];

endmodule

// File: rtl/sumador_restador_serie.sv
// Digit-serial adder/subtractor with accumulator, valid/ready handshakes and
// registered status flags; one CHUNK-bit slice is reused for N = WIDTH/CHUNK steps.
//
// state   | meaning
// IDLE    | waiting for an operation, in_ready = 1
// RUN     | one CHUNK-bit step per enabled cycle, LSB first
// DONE    | result and flags held, out_valid = 1, until out_ready
module sumador_restador_serie
    import sumador_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHUNK    = 2,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int N  = WIDTH / CHUNK;
    localparam int SW = (N > 1) ? $clog2(N) : 1;
    localparam logic [SW-1:0]    LAST    = SW'(N - 1);
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    generate
        if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("sumador_restador_serie: CHUNK must divide WIDTH and WIDTH must be >= 2");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d, sh_q, sh_d, acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             c_q, c_d;
    logic [SW-1:0]    step_q, step_d;
    logic             carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d, neg_q, neg_d;

    logic [CHUNK-1:0] f_sum;
    logic             f_cout, f_cmsb;
    logic [WIDTH-1:0] sum_ext, sh_next, res_fin;
    logic             ovf_fin;

    sumador_fragmento #(.CHUNK(CHUNK)) u_fragmento (
        .x    (x_q[CHUNK-1:0]),
        .y    (y_q[CHUNK-1:0]),
        .cin  (c_q),
        .sum  (f_sum),
        .cout (f_cout),
        .cmsb (f_cmsb)
    );

    // New digits enter from the MSB side so after N steps the word is aligned.
    assign sum_ext = WIDTH'(f_sum);
    assign sh_next = (sh_q >> CHUNK) | (sum_ext << (WIDTH - CHUNK));
    assign ovf_fin = f_cmsb ^ f_cout;
    assign res_fin = (SATURATE && ovf_fin) ? (sh_next[WIDTH-1] ? MAX_POS : MIN_NEG) : sh_next;

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        c_d      = c_q;
        step_d   = step_q;
        sh_d     = sh_q;
        acc_d    = acc_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        if (ena) begin
            if (acc_clr) begin
                acc_d = '0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        x_d     = op_uses_acc(op) ? (acc_clr ? '0 : acc_q) : a;
                        y_d     = op_is_sub(op) ? ~b : b;
                        c_d     = op_is_sub(op);
                        step_d  = '0;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    x_d    = x_q >> CHUNK;
                    y_d    = y_q >> CHUNK;
                    c_d    = f_cout;
                    sh_d   = sh_next;
                    step_d = step_q + 1'b1;
                    // Completion load takes priority over a coincident acc_clr.
                    if (step_q == LAST) begin
                        state_d  = ST_DONE;
                        result_d = res_fin;
                        carry_d  = f_cout;
                        ovf_d    = ovf_fin;
                        zero_d   = (res_fin == '0);
                        neg_d    = res_fin[WIDTH-1];
                        acc_d    = res_fin;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            c_q      <= 1'b0;
            step_q   <= '0;
            sh_q     <= '0;
            acc_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            c_q      <= c_d;
            step_q   <= step_d;
            sh_q     <= sh_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;
    assign negative  = neg_q;

endmodule

// File: tb/tb_sumador_restador_serie.sv
// Bench for sumador_restador_serie: five instances (CHUNK 2/2sat/1/4/8, WIDTH 8)
// checked against an arithmetic reference model of the operations and accumulator.
module tb_sumador_restador_serie;

    localparam int NI = 5;

    logic       clk = 1'b0;
    logic       rst_n, ena, acc_clr;
    logic [7:0] a, b;
    logic [1:0] op;
    logic [NI-1:0] in_valid, in_ready, out_valid, out_ready;
    logic [NI-1:0] carry_w, ovf_w, zero_w, neg_w;
    logic [7:0]    result_w [NI];
    logic [7:0]    acc_m [NI];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int CH  = (g == 2) ? 1 : (g == 3) ? 4 : (g == 4) ? 8 : 2;
        localparam bit SAT = (g == 1);
        sumador_restador_serie #(.WIDTH(8), .CHUNK(CH), .SATURATE(SAT)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .ena       (ena),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .a         (a),
            .b         (b),
            .op        (op),
            .acc_clr   (acc_clr),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .result    (result_w[g]),
            .carry     (carry_w[g]),
            .overflow  (ovf_w[g]),
            .zero      (zero_w[g]),
            .negative  (neg_w[g])
        );
    end

    function automatic int n_of(input int k);
        case (k)
            2:       return 8;
            3:       return 2;
            4:       return 1;
            default: return 4;
        endcase
    endfunction

    // Reference: true signed/unsigned arithmetic on integers.
    task automatic model(input int k, input logic [7:0] ai, input logic [7:0] bi,
                         input logic [1:0] opi, input bit clr,
                         output logic [7:0] r, output logic c, output logic v,
                         output logic z, output logic n);
        int x, sx, sb, s, u;
        if (clr) for (int i = 0; i < NI; i++) acc_m[i] = 8'h00;
        x  = opi[1] ? int'(acc_m[k]) : int'(ai);
        sx = (x >= 128) ? x - 256 : x;
        sb = (int'(bi) >= 128) ? int'(bi) - 256 : int'(bi);
        if (opi[0]) begin
            u = x + (255 - int'(bi)) + 1;
            s = sx - sb;
        end else begin
            u = x + int'(bi);
            s = sx + sb;
        end
        r = u[7:0];
        c = u[8];
        v = (s > 127) || (s < -128);
        if (v && k == 1) r = (s > 127) ? 8'h7F : 8'h80;
        z = (r == 8'h00);
        n = r[7];
        acc_m[k] = r;
    endtask

    task automatic do_op(input int k, input logic [7:0] ai, input logic [7:0] bi,
                         input logic [1:0] opi, input bit clr, input bit stall,
                         input int hold, input string name);
        logic [7:0] er;
        logic ec, ev, ez, en;
        int lat, lows;
        ena = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready[k] !== 1'b1) begin
            errors++;
            $display("FAIL %s in_ready_before_accept: got %b want 1", name, in_ready[k]);
        end
        a = ai; b = bi; op = opi; acc_clr = clr; in_valid[k] = 1'b1;
        model(k, ai, bi, opi, clr, er, ec, ev, ez, en);
        @(posedge clk);
        #1;
        in_valid[k] = 1'b0;
        acc_clr = 1'b0;
        lat = 0;
        lows = 0;
        do begin
            if (stall) ena = 1'($urandom_range(0, 1));
            @(posedge clk);
            if (!ena) lows++;
            lat++;
            #1;
        end while (!out_valid[k] && lat < 200);
        ena = 1'b1;
        checks++;
        if (out_valid[k] !== 1'b1 || lat != n_of(k) + lows) begin
            errors++;
            $display("FAIL %s latency: got %0d (out_valid %b) want %0d", name, lat, out_valid[k], n_of(k) + lows);
        end
        @(negedge clk);
        checks++;
        if (result_w[k] !== er) begin
            errors++;
            $display("FAIL %s result: got %h want %h", name, result_w[k], er);
        end
        checks++;
        if ({carry_w[k], ovf_w[k], zero_w[k], neg_w[k]} !== {ec, ev, ez, en}) begin
            errors++;
            $display("FAIL %s flags c/v/z/n: got %b want %b", name,
                     {carry_w[k], ovf_w[k], zero_w[k], neg_w[k]}, {ec, ev, ez, en});
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (result_w[k] !== er || in_ready[k] !== 1'b0 || out_valid[k] !== 1'b1) begin
                errors++;
                $display("FAIL %s done_hold: result %h in_ready %b out_valid %b want %h 0 1",
                         name, result_w[k], in_ready[k], out_valid[k], er);
            end
        end
        out_ready[k] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[k] = 1'b0;
        checks++;
        if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1) begin
            errors++;
            $display("FAIL %s release: out_valid %b in_ready %b want 0 1", name, out_valid[k], in_ready[k]);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        for (int k = 0; k < NI; k++) begin
            checks++;
            if ({in_ready[k], out_valid[k], carry_w[k], ovf_w[k], zero_w[k], neg_w[k], result_w[k]} !== 14'b10_0000_0000_0000) begin
                errors++;
                $display("FAIL %s inst%0d: rdy %b vld %b c%b v%b z%b n%b res %h want rdy1 vld0 flags0 res00",
                         name, k, in_ready[k], out_valid[k], carry_w[k], ovf_w[k], zero_w[k], neg_w[k], result_w[k]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; acc_clr = 1'b0; a = '0; b = '0; op = '0;
        in_valid = '0; out_ready = '0;
        for (int i = 0; i < NI; i++) acc_m[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        do_op(0, 8'h25, 8'h13, 2'b00, 1'b0, 1'b0, 0, "add_25_13");
        do_op(0, 8'h10, 8'h20, 2'b01, 1'b0, 1'b0, 0, "sub_10_20");
        do_op(0, 8'h33, 8'h33, 2'b01, 1'b0, 1'b0, 0, "sub_33_33");
        do_op(0, 8'h70, 8'h20, 2'b00, 1'b0, 1'b0, 0, "ovf_nosat");
        do_op(1, 8'h70, 8'h20, 2'b00, 1'b0, 1'b0, 0, "ovf_sat_pos");
        do_op(1, 8'h80, 8'h01, 2'b01, 1'b0, 1'b0, 0, "ovf_sat_neg");
    endtask

    task automatic test_accumulate();
        @(negedge clk);
        acc_clr = 1'b1;
        @(posedge clk);
        #1;
        acc_clr = 1'b0;
        for (int i = 0; i < NI; i++) acc_m[i] = 8'h00;
        repeat (3) do_op(0, 8'hAA, 8'h05, 2'b10, 1'b0, 1'b0, 0, "acc_add");
        do_op(0, 8'hAA, 8'h10, 2'b11, 1'b0, 1'b0, 0, "acc_sub");
        do_op(0, 8'h00, 8'h01, 2'b10, 1'b1, 1'b0, 0, "acc_clr_on_accept");
    endtask

    task automatic test_stall();
        do_op(0, 8'h25, 8'h13, 2'b00, 1'b0, 1'b1, 0, "stall_add");
        do_op(2, 8'h5A, 8'hC3, 2'b01, 1'b0, 1'b1, 0, "stall_sub_c1");
        do_op(0, 8'h44, 8'h11, 2'b00, 1'b0, 1'b0, 5, "done_hold");
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        a = 8'h25; b = 8'h13; op = 2'b00; in_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) acc_m[i] = 8'h00;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        do_op(0, 8'h00, 8'h07, 2'b10, 1'b0, 1'b0, 0, "after_reset_acc");
    endtask

    task automatic test_chunk_sweep();
        do_op(2, 8'h25, 8'h13, 2'b00, 1'b0, 1'b0, 0, "chunk1_add");
        do_op(3, 8'h25, 8'h13, 2'b00, 1'b0, 1'b0, 0, "chunk4_add");
        do_op(4, 8'h25, 8'h13, 2'b00, 1'b0, 1'b0, 0, "chunk8_add");
    endtask

    task automatic test_back_to_back();
        logic [7:0] er;
        logic ec, ev, ez, en;
        int prev, cnt;
        @(negedge clk);
        a = 8'h19; b = 8'h27; op = 2'b00;
        in_valid[0] = 1'b1; out_ready[0] = 1'b1;
        model(0, 8'h19, 8'h27, 2'b00, 1'b0, er, ec, ev, ez, en);
        prev = -1;
        cnt = 0;
        for (int i = 1; i <= 18; i++) begin
            @(posedge clk);
            #1;
            if (out_valid[0]) begin
                cnt++;
                checks++;
                if (result_w[0] !== er) begin
                    errors++;
                    $display("FAIL b2b_result: got %h want %h", result_w[0], er);
                end
                if (prev >= 0) begin
                    checks++;
                    if (i - prev != 6) begin
                        errors++;
                        $display("FAIL b2b_spacing: got %0d want 6", i - prev);
                    end
                end
                prev = i;
            end
        end
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b0;
        checks++;
        if (cnt != 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d want 3", cnt);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            do_op(int'($urandom_range(0, NI - 1)), 8'($urandom), 8'($urandom), 2'($urandom),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), 0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_accumulate();
        test_stall();
        test_mid_reset();
        test_chunk_sweep();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
